ram_burst_master: RTL and testbench
===================================

// Module: ram_burst_master
// PURPOSE
//  Burst initiator for the single-port RAM (synchronous write, asynchronous read).
//  Accepts one command (write/read, start address, beat count) and then streams the data.
//  Writes take beats from a valid/ready input stream. Reads return beats on a valid/ready output stream.
//  Sits between client logic and the ram's clk/address_in/data_in/write_enable/data_out pins.
// PARAMETERS
//  AW  8  address width; RAM depth 2**AW
//  DW  8  data width
//  LW  8  width of cmd_len (beats-1)
// PORTS
//  clk               in   1   rising-edge clock, shared with ram
//  reset             in   1   synchronous, active-high
//  cmd_valid         in   1   command offered
//  cmd_ready         out  1   command accepted when valid&ready
//  cmd_write         in   1   1=write burst, 0=read burst
//  cmd_addr          in   AW  start address
//  cmd_len           in   LW  beats minus one (0 => 1 beat)
//  wr_valid          in   1   write beat offered
//  wr_ready          out  1   write beat accepted when valid&ready
//  wr_data           in   DW  write beat data
//  rd_valid          out  1   read beat offered
//  rd_ready          in   1   consumer accepts read beat
//  rd_data           out  DW  read beat data
//  busy              out  1   state != IDLE
//  done              out  1   one-cycle pulse at end of burst
//  err               out  1   one-cycle pulse, rejected command (0 unless BURST_BOUND_CHECK_EN)
//  ram_address       out  AW  to ram address_in
//  ram_data_in       out  DW  to ram data_in
//  ram_write_enable  out  1   to ram write_enable
//  ram_data_out      in   DW  from ram data_out (combinational)
// BEHAVIOUR
//  Reset: state=IDLE; addr/remaining/rd_data=0; rd_valid=done=err=0; cmd_ready=1 on first post-reset cycle.
//  ram_write_enable is gated by !reset combinationally: no RAM write on any edge where reset=1.
//  Reset mid-burst abandons the burst. Remaining beats are not accepted. RAM contents are untouched.
//  FSM states: IDLE, WRITE, READ, LAST_RD, DONE.
//  IDLE: cmd_ready=1. On handshake: addr<=cmd_addr, remaining<=cmd_len; next state = cmd_write ? WRITE : READ.
//  cmd_ready=0 in every other state; commands are not accepted while busy.
//  WRITE: wr_ready=1.
//   - Combinational: ram_write_enable = wr_valid, ram_data_in = wr_data, ram_address = addr.
//   - The RAM writes on the same edge as the beat handshake.
//   - Per beat: remaining==0 -> DONE; else addr<=addr+1, remaining<=remaining-1.
//   - wr_valid low = stall; no write, no state change.
//  READ: ram_address = addr. Capture when cap = !rd_valid | rd_ready.
//   - On cap: rd_data<=ram_data_out, rd_valid<=1.
//   - Then remaining==0 -> LAST_RD; else addr++, remaining--.
//   - rd_data/rd_valid are held stable while rd_valid & !rd_ready.
//  LAST_RD: on rd_ready, rd_valid<=0 -> DONE.
//  DONE: done=1 for exactly one cycle -> IDLE.
//  Latency: first rd_valid 2 cycles after cmd handshake. Throughput 1 beat/cycle when unstalled.
//  Address arithmetic is modulo 2**AW (255+1 -> 0).
//  Outside WRITE: ram_write_enable=0, ram_data_in=0.
// CONFIGURATION
//  BURST_BOUND_CHECK_EN defined:
//   - A command with cmd_addr+cmd_len > 2**AW-1 is still handshaked but goes IDLE -> DONE.
//   - err=1 and done=1 in that DONE cycle; no RAM access, no wr_ready, no rd_valid.
//  BURST_BOUND_CHECK_EN undefined: err is tied to 0 and bursts wrap past the top address to 0.
// TESTING (AW=DW=LW=8)
//  1. reset high 2 cycles -> cmd_ready=1, busy=0, rd_valid=0, ram_write_enable=0, done=0.
//  2. write addr=8 len=2, data 5,6,7 with wr_valid held 1 -> ram_write_enable high 3 cycles at addr 8,9,10; done pulses 1 cycle later.
//  3. read addr=8 len=2, rd_ready=1 -> rd_data 5,6,7 on 3 consecutive cycles; first rd_valid 2 cycles after handshake; done once.
//  4. read addr=8 len=2, rd_ready pattern 1,0,0,1,1 -> exactly 5,6,7 delivered; rd_data stable during stall.
//  5. write addr=254 len=3 -> undefined macro: writes 254,255,0,1. Defined: err+done pulse, ram_write_enable never 1.
//  6. reset asserted after 2 beats of a 4-beat write -> no write on reset edge; next cycle IDLE, cmd_ready=1; addr 10 keeps old value.

Source files
------------

// File: rtl/ram_burst_master.sv
// Burst initiator for a single-port RAM (synchronous write, asynchronous read).
// Accepts one command (write/read, start address, beat count) and streams the beats:
// writes come from a valid/ready input stream, reads leave on a valid/ready output stream.
// Optional feature macro: BURST_BOUND_CHECK_EN. When it is defined, a burst that would run
// past the top address is rejected with an err+done pulse. When it is undefined, err stays 0
// and addresses wrap to 0.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | cmd_ready=1, waiting for a command handshake
// WRITE   | wr_ready=1, each accepted beat is written to the RAM at once
// READ    | RAM data is captured into rd_data whenever the output slot frees
// LAST_RD | final read beat is held until the consumer takes it
// DONE    | done pulse for one cycle, err as well if the command was rejected
module ram_burst_master #(
  parameter int AW = 8,
  parameter int DW = 8,
  parameter int LW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_addr,
  input  logic [LW-1:0] cmd_len,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [DW-1:0] wr_data,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [DW-1:0] rd_data,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] ram_address,
  output logic [DW-1:0] ram_data_in,
  output logic          ram_write_enable,
  input  logic [DW-1:0] ram_data_out
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WRITE   = 3'd1,
    S_READ    = 3'd2,
    S_LAST_RD = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [LW-1:0] rem_q, rem_d;
  logic [DW-1:0] rd_data_q, rd_data_d;
  logic          rd_valid_q, rd_valid_d;
  logic          cap;

`ifdef BURST_BOUND_CHECK_EN
  logic          err_q, err_d;
  logic [AW+LW:0] end_addr;
  logic          out_of_bound;

  // Last address of the requested burst, widened so it cannot overflow
  assign end_addr     = {{(LW+1){1'b0}}, cmd_addr} + {{(AW+1){1'b0}}, cmd_len};
  assign out_of_bound = |end_addr[AW+LW:AW];
  assign err          = err_q;
`else
  assign err = 1'b0;
`endif

  // The read output slot can take a new beat when it is empty or being drained
  assign cap = !rd_valid_q || rd_ready;

  // Outputs decoded from registered state; the RAM write is also blocked while reset is high
  assign cmd_ready        = (state_q == S_IDLE);
  assign busy             = (state_q != S_IDLE);
  assign done             = (state_q == S_DONE);
  assign wr_ready         = (state_q == S_WRITE);
  assign rd_valid         = rd_valid_q;
  assign rd_data          = rd_data_q;
  assign ram_address      = addr_q;
  assign ram_write_enable = (state_q == S_WRITE) && wr_valid && !reset;
  assign ram_data_in      = (state_q == S_WRITE) ? wr_data : '0;

  // Next-state and datapath computation
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_valid_q;
`ifdef BURST_BOUND_CHECK_EN
    err_d      = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          addr_d = cmd_addr;
          rem_d  = cmd_len;
`ifdef BURST_BOUND_CHECK_EN
          if (out_of_bound) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end else begin
            state_d = cmd_write ? S_WRITE : S_READ;
          end
`else
          state_d = cmd_write ? S_WRITE : S_READ;
`endif
        end
      end
      S_WRITE: begin
        if (wr_valid) begin
          if (rem_q == '0) begin
            state_d = S_DONE;
          end else begin
            addr_d = addr_q + AW'(1);
            rem_d  = rem_q - LW'(1);
          end
        end
      end
      S_READ: begin
        if (cap) begin
          rd_data_d  = ram_data_out;
          rd_valid_d = 1'b1;
          if (rem_q == '0) begin
            state_d = S_LAST_RD;
          end else begin
            addr_d = addr_q + AW'(1);
            rem_d  = rem_q - LW'(1);
          end
        end
      end
      S_LAST_RD: begin
        if (rd_ready) begin
          rd_valid_d = 1'b0;
          state_d    = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
`ifdef BURST_BOUND_CHECK_EN
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
`ifdef BURST_BOUND_CHECK_EN
      err_q      <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_ram_burst_master.sv
// Directed bench for ram_burst_master with a behavioural RAM attached to the ram_* pins.
module tb_ram_burst_master;

  logic       clk;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_len;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] wr_data;
  logic       rd_valid;
  logic       rd_ready;
  logic [7:0] rd_data;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] ram_address;
  logic [7:0] ram_data_in;
  logic       ram_write_enable;
  logic [7:0] ram_data_out;

  logic [7:0] mem [0:255];

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] got_q [$];
  logic [7:0] we_q  [$];
  int first_valid;
  int done_cnt;
  int done_cyc;
  int err_cnt;
  int wrr_cnt;

  ram_burst_master #(.AW(8), .DW(8), .LW(8)) dut (
    .clk              (clk),
    .reset            (reset),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_write        (cmd_write),
    .cmd_addr         (cmd_addr),
    .cmd_len          (cmd_len),
    .wr_valid         (wr_valid),
    .wr_ready         (wr_ready),
    .wr_data          (wr_data),
    .rd_valid         (rd_valid),
    .rd_ready         (rd_ready),
    .rd_data          (rd_data),
    .busy             (busy),
    .done             (done),
    .err              (err),
    .ram_address      (ram_address),
    .ram_data_in      (ram_data_in),
    .ram_write_enable (ram_write_enable),
    .ram_data_out     (ram_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM: synchronous write, asynchronous read
  always @(posedge clk) begin
    if (ram_write_enable) mem[ram_address] <= ram_data_in;
  end
  assign ram_data_out = mem[ram_address];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_write(input logic [7:0] a, input logic [7:0] l, input logic [7:0] base);
    int beats;
    beats = 0;
    we_q.delete();
    done_cnt = 0;
    done_cyc = -1;
    err_cnt = 0;
    wrr_cnt = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = a; cmd_len = l;
    #1 check("wr_cmd_ready", cmd_ready, 1);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      wr_valid = (beats <= int'(l));
      wr_data = base + beats[7:0];
      #1;
      if (ram_write_enable) we_q.push_back(ram_address);
      if (wr_ready) wrr_cnt++;
      if (wr_valid && wr_ready) beats++;
      if (err) err_cnt++;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (done_cyc >= 0 && c >= done_cyc + 2) break;
    end
    wr_valid = 1'b0;
    if (done_cyc < 0) check("wr_timeout", 0, 1);
  endtask

  task automatic run_read(input logic [7:0] a, input logic [7:0] l, input logic [15:0] pat, input int npat);
    logic       held_valid;
    logic [7:0] held_data;
    held_valid = 1'b0;
    held_data = '0;
    got_q.delete();
    first_valid = -1;
    done_cnt = 0;
    done_cyc = -1;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = a; cmd_len = l; rd_ready = 1'b1;
    #1 check("rd_cmd_ready", cmd_ready, 1);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      rd_ready = (c - 1 < npat) ? pat[c-1] : 1'b1;
      #1;
      if (held_valid) begin
        check("rd_stall_valid", rd_valid, 1);
        check("rd_stall_data", rd_data, held_data);
      end
      if (rd_valid && first_valid < 0) first_valid = c;
      if (rd_valid && rd_ready) got_q.push_back(rd_data);
      held_valid = rd_valid && !rd_ready;
      held_data = rd_data;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (done_cyc >= 0 && c >= done_cyc + 2) break;
    end
    rd_ready = 1'b1;
    if (done_cyc < 0) check("rd_timeout", 0, 1);
  endtask

  task automatic check_read_data(input string tag, input logic [7:0] d0);
    logic [7:0] v;
    check({tag, "_count"}, got_q.size(), 3);
    for (int i = 0; i < 3; i++) begin
      v = (i < got_q.size()) ? got_q[i] : 8'hxx;
      check($sformatf("%s_beat%0d", tag, i), v, d0 + 8'(i));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b1;

    // 1. reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_we", ram_write_enable, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);

    // 2. write 5,6,7 to 8..10
    run_write(8'd8, 8'd2, 8'd5);
    check("w1_we_count", we_q.size(), 3);
    check("w1_we_addr0", (we_q.size() > 0) ? we_q[0] : 8'hxx, 8);
    check("w1_we_addr1", (we_q.size() > 1) ? we_q[1] : 8'hxx, 9);
    check("w1_we_addr2", (we_q.size() > 2) ? we_q[2] : 8'hxx, 10);
    check("w1_done_cyc", done_cyc, 4);
    check("w1_done_cnt", done_cnt, 1);
    check("w1_mem8", mem[8], 5);
    check("w1_mem9", mem[9], 6);
    check("w1_mem10", mem[10], 7);
    check("w1_idle", cmd_ready, 1);

    // 3. read back with rd_ready held high
    run_read(8'd8, 8'd2, 16'hFFFF, 16);
    check("r1_first_valid", first_valid, 2);
    check_read_data("r1", 8'd5);
    check("r1_done_cyc", done_cyc, 5);
    check("r1_done_cnt", done_cnt, 1);

    // 4. read back with rd_ready pattern 1,0,0,1,1
    run_read(8'd8, 8'd2, 16'h0019, 5);
    check("r2_first_valid", first_valid, 2);
    check_read_data("r2", 8'd5);
    check("r2_done_cnt", done_cnt, 1);

    // 5. burst crossing the top address
    run_write(8'd254, 8'd3, 8'h11);
`ifdef BURST_BOUND_CHECK_EN
    check("w2_we_count", we_q.size(), 0);
    check("w2_wr_ready_cnt", wrr_cnt, 0);
    check("w2_err_cnt", err_cnt, 1);
    check("w2_done_cnt", done_cnt, 1);
    check("w2_done_cyc", done_cyc, 1);
`else
    check("w2_we_count", we_q.size(), 4);
    check("w2_we_addr0", (we_q.size() > 0) ? we_q[0] : 8'hxx, 254);
    check("w2_we_addr1", (we_q.size() > 1) ? we_q[1] : 8'hxx, 255);
    check("w2_we_addr2", (we_q.size() > 2) ? we_q[2] : 8'hxx, 0);
    check("w2_we_addr3", (we_q.size() > 3) ? we_q[3] : 8'hxx, 1);
    check("w2_err_cnt", err_cnt, 0);
    check("w2_done_cnt", done_cnt, 1);
    check("w2_mem255", mem[255], 8'h12);
    check("w2_mem0", mem[0], 8'h13);
    run_read(8'd255, 8'd2, 16'hFFFF, 16);
    check_read_data("r3_wrap", 8'h12);
`endif

    // 6. reset in the middle of a 4-beat write
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'd8; cmd_len = 8'd3;
    @(negedge clk);
    cmd_valid = 1'b0; wr_valid = 1'b1; wr_data = 8'hA0;
    @(negedge clk);
    wr_data = 8'hA1;
    @(negedge clk);
    wr_data = 8'hA2; reset = 1'b1;
    #1 check("rst_mid_we_gated", ram_write_enable, 0);
    @(negedge clk);
    reset = 1'b0; wr_data = 8'hA3;
    #1;
    check("rst_mid_cmd_ready", cmd_ready, 1);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_wr_ready", wr_ready, 0);
    check("rst_mid_we", ram_write_enable, 0);
    wr_valid = 1'b0;
    @(negedge clk);
    check("rst_mid_mem8", mem[8], 8'hA0);
    check("rst_mid_mem9", mem[9], 8'hA1);
    check("rst_mid_mem10", mem[10], 8'd7);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
